// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// One request is outstanding at a time; imem_ready is a one-cycle response strobe.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: PC register, imem request handshake, one-entry skid buffer and the
// IF/ID pipeline register, with EX redirect and load-use stall handling.
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    imem,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDrain
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] drain_addr_q;
  logic [XLEN-1:0] buf_pc_q;
  logic [31:0]     buf_instr_q;

  logic            hold;
  logic [XLEN-1:0] pc_inc;

  assign hold   = !pc_write || !if_id_write;
  assign pc_inc = pc_q + XLEN'(4);

  // DRAIN keeps presenting the abandoned address until its response is consumed.
  always_comb begin
    imem.imem_req  = (state_q == StFetch) || (state_q == StDrain);
    imem.imem_addr = (state_q == StDrain) ? drain_addr_q : pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      buf_pc_q     <= '0;
      buf_instr_q  <= NOP_INSTR;
      if_id_pc     <= '0;
      if_id_instr  <= NOP_INSTR;
      if_id_valid  <= 1'b0;
    end else if (redirect_valid) begin
      pc_q        <= redirect_pc;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      unique case (state_q)
        StFetch: begin
          if (imem.imem_ready) begin
            state_q <= StFetch;
          end else begin
            drain_addr_q <= pc_q;
            state_q      <= StDrain;
          end
        end
        StDrain: state_q <= StDrain;
        default: state_q <= StFetch;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
        end
        StFetch: begin
          if (imem.imem_ready) begin
            if (hold) begin
              buf_pc_q    <= pc_q;
              buf_instr_q <= imem.imem_rdata;
              state_q     <= StHold;
            end else begin
              if_id_pc    <= pc_q;
              if_id_instr <= imem.imem_rdata;
              if_id_valid <= 1'b1;
              pc_q        <= pc_inc;
            end
          end else if (!hold) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end
        end
        StHold: begin
          if (!hold) begin
            if_id_pc    <= buf_pc_q;
            if_id_instr <= buf_instr_q;
            if_id_valid <= 1'b1;
            pc_q        <= pc_inc;
            state_q     <= StFetch;
          end
        end
        StDrain: begin
          if (imem.imem_ready) begin
            state_q <= StFetch;
          end
          if (!hold) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect/latency
// traffic, each cycle checked against a transaction-level model of the IF stage.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b1;
  logic        if_id_write = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  fetch_unit_if #(.XLEN(32)) imem_bus ();

  fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory side: responds after mem_lat wait cycles of an asserted request.
  int lat_fixed  = 0;
  bit lat_random = 1'b0;
  int mem_cnt    = 0;
  int mem_lat    = 0;

  // Model: what the fetch stage owes the pipeline, in terms of pending work.
  bit          m_started;
  bit          m_discard;
  bit          m_buf_valid;
  logic [31:0] m_pc;
  logic [31:0] m_drain_addr;
  logic [31:0] m_buf_pc;
  logic [31:0] m_buf_instr;
  logic [31:0] m_ifid_pc;
  logic [31:0] m_ifid_instr;
  bit          m_ifid_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h0010_0113;
      32'h0000_0008: return 32'h0020_8193;
      default:       return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  function automatic int next_lat();
    return lat_random ? int'($urandom_range(0, 3)) : lat_fixed;
  endfunction

  task automatic set_latency(input int lat);
    lat_random = 1'b0;
    lat_fixed  = lat;
    mem_lat    = lat;
    mem_cnt    = 0;
  endtask

  task automatic model_reset();
    m_started    = 1'b0;
    m_discard    = 1'b0;
    m_buf_valid  = 1'b0;
    m_pc         = 32'h0;
    m_drain_addr = 32'h0;
    m_buf_pc     = 32'h0;
    m_buf_instr  = NOP;
    m_ifid_pc    = 32'h0;
    m_ifid_instr = NOP;
    m_ifid_valid = 1'b0;
    mem_cnt      = 0;
    mem_lat      = next_lat();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = '0;
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // One pipeline cycle, entered and left just after a falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit pw, input bit iw,
                      input bit spurious);
    bit          ready;
    bit          hold;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;

    exp_req  = m_started && !m_buf_valid;
    exp_addr = m_discard ? m_drain_addr : m_pc;
    n_checks++;
    if (imem_bus.imem_req !== exp_req) begin
      n_fail++;
      $display("FAIL imem_req @%0t: got %b expected %b", $time, imem_bus.imem_req, exp_req);
    end
    if (exp_req) begin
      n_checks++;
      if (imem_bus.imem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL imem_addr @%0t: got %h expected %h", $time, imem_bus.imem_addr, exp_addr);
      end
    end

    ready = 1'b0;
    rdata = $urandom;
    if (imem_bus.imem_req === 1'b1) begin
      if (mem_cnt >= mem_lat) begin
        ready   = 1'b1;
        rdata   = mem_word(imem_bus.imem_addr);
        mem_cnt = 0;
        mem_lat = next_lat();
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
    if (spurious) ready = 1'b1;

    pc_write            = pw;
    if_id_write         = iw;
    redirect_valid      = redir;
    redirect_pc         = rpc;
    imem_bus.imem_ready = ready;
    imem_bus.imem_rdata = rdata;
    hold = !pw || !iw;

    if (redir) begin
      if (m_started && !m_buf_valid && !m_discard && !ready) begin
        m_discard    = 1'b1;
        m_drain_addr = m_pc;
      end
      m_started    = 1'b1;
      m_buf_valid  = 1'b0;
      m_pc         = rpc;
      m_ifid_valid = 1'b0;
      m_ifid_instr = NOP;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_discard) begin
      if (ready) m_discard = 1'b0;
      if (!hold) begin
        m_ifid_valid = 1'b0;
        m_ifid_instr = NOP;
      end
    end else if (m_buf_valid) begin
      if (!hold) begin
        m_ifid_pc    = m_buf_pc;
        m_ifid_instr = m_buf_instr;
        m_ifid_valid = 1'b1;
        m_pc         = m_pc + 32'd4;
        m_buf_valid  = 1'b0;
      end
    end else if (ready) begin
      if (hold) begin
        m_buf_valid = 1'b1;
        m_buf_pc    = m_pc;
        m_buf_instr = rdata;
      end else begin
        m_ifid_pc    = m_pc;
        m_ifid_instr = rdata;
        m_ifid_valid = 1'b1;
        m_pc         = m_pc + 32'd4;
      end
    end else if (!hold) begin
      m_ifid_valid = 1'b0;
      m_ifid_instr = NOP;
    end

    @(posedge clk);
    @(negedge clk);
    redirect_valid      = 1'b0;
    imem_bus.imem_ready = 1'b0;

    n_checks++;
    if (if_id_valid !== m_ifid_valid || if_id_instr !== m_ifid_instr) begin
      n_fail++;
      $display("FAIL if_id @%0t: got valid=%b instr=%h expected valid=%b instr=%h", $time,
               if_id_valid, if_id_instr, m_ifid_valid, m_ifid_instr);
    end
    if (m_ifid_valid) begin
      n_checks++;
      if (if_id_pc !== m_ifid_pc) begin
        n_fail++;
        $display("FAIL if_id_pc @%0t: got %h expected %h", $time, if_id_pc, m_ifid_pc);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_bus.imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (imem_bus.imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== NOP ||
        if_id_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got req=%b valid=%b instr=%h pc=%h expected 0/0/%h/0",
               imem_bus.imem_req, if_id_valid, if_id_instr, if_id_pc, NOP);
    end
  endtask

  task automatic test_zero_wait_and_stall();
    set_latency(0);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL first_fetch: got req=%b addr=%h expected 1/00000000",
               imem_bus.imem_req, imem_bus.imem_addr);
    end
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (if_id_pc !== 32'h0 || if_id_instr !== 32'h00A0_0093 || if_id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_wait_0: got %h/%h/%b expected 00000000/00a00093/1",
               if_id_pc, if_id_instr, if_id_valid);
    end
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (if_id_pc !== 32'h4 || if_id_instr !== 32'h0010_0113 || if_id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_wait_4: got %h/%h/%b expected 00000004/00100113/1",
               if_id_pc, if_id_instr, if_id_valid);
    end
    // Response for 0x8 lands while stalled and must be parked.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (imem_bus.imem_req !== 1'b0 || if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got req=%b pc=%h valid=%b expected 0/00000004/1", i,
                 imem_bus.imem_req, if_id_pc, if_id_valid);
      end
    end
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (if_id_pc !== 32'h8 || if_id_instr !== 32'h0020_8193 || if_id_valid !== 1'b1 ||
        imem_bus.imem_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL stall_release: got %h/%h/%b next=%h expected 00000008/00208193/1 next=c",
               if_id_pc, if_id_instr, if_id_valid, imem_bus.imem_addr);
    end
  endtask

  task automatic test_latency();
    int valids;
    int bubbles;
    set_latency(2);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    valids  = 0;
    bubbles = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (if_id_valid === 1'b1) valids++;
      else if (if_id_instr === NOP) bubbles++;
    end
    n_checks++;
    if (valids != 4 || bubbles != 8) begin
      n_fail++;
      $display("FAIL latency_bubbles: got valid=%0d bubble=%0d expected 4/8", valids, bubbles);
    end
  endtask

  task automatic test_redirect_drain();
    bit found;
    set_latency(0);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h10, 1'b1, 1'b1, 1'b0);
    set_latency(3);
    step(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h10 || if_id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_entry: got req=%b addr=%h valid=%b expected 1/00000010/0",
               imem_bus.imem_req, imem_bus.imem_addr, if_id_valid);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (if_id_valid === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || if_id_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL drain_first_valid: got found=%b pc=%h expected 1/00000100", found, if_id_pc);
    end
  endtask

  task automatic test_redirect_hold();
    set_latency(0);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h200 || if_id_valid !== 1'b0 ||
        if_id_instr !== NOP) begin
      n_fail++;
      $display("FAIL redirect_hold: got req=%b addr=%h valid=%b instr=%h expected 1/200/0/%h",
               imem_bus.imem_req, imem_bus.imem_addr, if_id_valid, if_id_instr, NOP);
    end
  endtask

  task automatic test_wrap();
    set_latency(0);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (if_id_pc !== 32'hFFFF_FFFC || if_id_valid !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: got pc=%h valid=%b next=%h expected fffffffc/1/00000000",
               if_id_pc, if_id_valid, imem_bus.imem_addr);
    end
  endtask

  task automatic test_async_reset();
    set_latency(3);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_bus.imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== NOP ||
        if_id_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b valid=%b instr=%h pc=%h expected 0/0/%h/0",
               imem_bus.imem_req, if_id_valid, if_id_instr, if_id_pc, NOP);
    end
    @(negedge clk);
    set_latency(0);
    model_reset();
    rst_n = 1'b1;
    // Stray strobe in IDLE must not be taken as an instruction.
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_fetch: got req=%b addr=%h valid=%b expected 1/00000000/0",
               imem_bus.imem_req, imem_bus.imem_addr, if_id_valid);
    end
  endtask

  task automatic test_random();
    bit          redir;
    bit          pw;
    bit          iw;
    int          r;
    logic [31:0] target;
    lat_random = 1'b1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      redir  = ($urandom_range(0, 99) < 8);
      target = $urandom & 32'h0000_FFFC;
      r      = int'($urandom_range(0, 9));
      pw     = !(r == 0 || r == 1);
      iw     = !(r == 0 || r == 2);
      step(redir, target, pw, iw, 1'b0);
    end
    lat_random = 1'b0;
  endtask

  initial begin
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = '0;
    test_reset();
    test_zero_wait_and_stall();
    test_latency();
    test_redirect_drain();
    test_redirect_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the five-stage pipeline. Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes the load-use stall controls (pc_write, if_id_write) and the EX-stage branch/jump redirect.
- Produces the IF/ID instruction stream: valid instructions, or NOP bubbles when fetch cannot supply one.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_write  in  1  0 freezes PC (stall).
- if_id_write  in  1  0 freezes IF/ID (stall).
- redirect_valid  in  1  taken branch/jump from EX, single-cycle pulse.
- redirect_pc  in  XLEN  target address, valid with redirect_valid.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address, stable while imem_req high and imem_ready low.
- imem_ready  in  1  response strobe, one cycle, with imem_rdata.
- imem_rdata  in  32  fetched instruction.
- if_id_pc  out  XLEN  PC of instruction in IF/ID.
- if_id_instr  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Definitions: hold = !pc_write || !if_id_write. All state updates occur on the rising clk edge.
- Reset (async assert, sync release):
  - pc=RESET_PC, state=IDLE.
  - if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, buffer empty.
  - imem_req=0.
- States:
  - IDLE: imem_req=0. Goes to FETCH next cycle unconditionally.
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0. Skid buffer holds a fetched instruction.
  - DRAIN: imem_req=1, imem_addr=stale address. Waits to discard one response.
- Priority: redirect_valid over everything. On a redirect edge:
  - pc<=redirect_pc, IF/ID<=bubble (valid 0, NOP_INSTR), buffer cleared. Applies even when hold=1.
  - FETCH with imem_ready=0 -> DRAIN; the held address is kept until the response returns.
  - FETCH with imem_ready=1 -> FETCH; imem_rdata is discarded.
  - HOLD or IDLE -> FETCH.
  - DRAIN -> DRAIN.
- FETCH, no redirect:
  - imem_ready=1, hold=0: IF/ID<={pc, imem_rdata, 1}, pc<=pc+4, stay in FETCH. Throughput is 1 instr/cycle for a zero-wait memory.
  - imem_ready=1, hold=1: buffer<={pc, imem_rdata}, state->HOLD. IF/ID and pc are unchanged.
  - imem_ready=0, hold=0: IF/ID<=bubble, pc unchanged.
  - imem_ready=0, hold=1: IF/ID unchanged.
- HOLD, no redirect:
  - hold=0: IF/ID<={buffer, 1}, pc<=pc+4, state->FETCH.
  - hold=1: everything unchanged.
- DRAIN, no redirect:
  - imem_ready=1: discard the response, state->FETCH (new pc is already loaded).
  - imem_ready=0: stay in DRAIN.
  - While in DRAIN, if hold=0, IF/ID<=bubble.
- A second redirect while in DRAIN overwrites pc. Only one response is ever outstanding, so one discard is sufficient.
- pc+4 wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000). No alignment checks.
- Reset asserted mid-transaction aborts immediately. Any response arriving after reset release, before the first request, is ignored (state IDLE).
- Outputs are registered except imem_req/imem_addr, which decode from state and pc (DRAIN uses a saved address register).

Test Plan:
- Reset then zero-wait memory returning 0x00A00093, 0x00100113 -> first fetch addr 0x0 one cycle after release; IF/ID shows pc 0x0 then 0x4, valid=1 on consecutive cycles.
- Stall (pc_write=if_id_write=0) for 2 cycles with response 0x00208193 arriving at pc 0x8 -> state HOLD, imem_req=0, IF/ID frozen; on release IF/ID={0x8, 0x00208193, 1}; next request is at 0xC.
- Memory with 3-cycle latency -> imem_addr constant across wait; IF/ID shows 2 bubbles (NOP_INSTR, valid 0) per instruction when not stalled.
- Redirect to 0x100 while a request to 0x10 is outstanding -> DRAIN; response for 0x10 discarded; next request is at 0x100; IF/ID bubble; first valid IF/ID pc=0x100.
- Redirect to 0x200 in the same cycle as imem_ready and hold=1 -> no HOLD entry, buffer empty, IF/ID bubble, next request at 0x200.
- pc=0xFFFF_FFFC fetched without stall -> next imem_addr=0x0; async reset asserted during WAIT -> outputs at reset values immediately, first request at RESET_PC.
